// File: rtl/latch_sr_pkg.sv
// Shared definitions for the latch_sr flag-storage bank: forbidden-state
// policy encodings and the synchronizer depth limit.
package latch_sr_pkg;

  typedef enum logic [1:0] {
    POL_NOR      = 2'd0,
    POL_RST_WINS = 2'd1,
    POL_SET_WINS = 2'd2,
    POL_HOLD     = 2'd3
  } policy_e;

  localparam int unsigned MAX_SYNC_STAGES = 3;

endpackage

// File: rtl/latch_sr_if.sv
// Bundle of the set/reset request lines and the stored-value/status outputs.
interface latch_sr_if #(
  parameter int unsigned WIDTH = 1
);

  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] R;
  logic             err_clr;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] QN;
  logic [WIDTH-1:0] invalid;
  logic             err_sticky;

  modport master (
    output S, R, err_clr,
    input  Q, QN, invalid, err_sticky
  );

  modport slave (
    input  S, R, err_clr,
    output Q, QN, invalid, err_sticky
  );

endinterface

// File: rtl/latch_sr_cell.sv
// One clocked SR storage bit: optional input synchronizer, state flop with
// configurable S=R=1 response, and a registered invalid flag.
module latch_sr_cell
  import latch_sr_pkg::*;
#(
  parameter int unsigned SYNC_STAGES      = 0,
  parameter int unsigned FORBIDDEN_POLICY = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_s,
  input  logic i_r,
  output logic o_q,
  output logic o_qn,
  output logic o_invalid,
  output logic o_forbidden
);

  localparam policy_e POLICY = policy_e'(FORBIDDEN_POLICY[1:0]);

  logic w_s;
  logic w_r;
  logic w_forbidden;
  logic w_next;
  logic r_q;
  logic r_qn;
  logic r_invalid;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s = i_s;
      assign w_r = i_r;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_s_sync;
      logic [SYNC_STAGES-1:0] r_r_sync;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_s_sync <= '0;
          r_r_sync <= '0;
        end else begin
          r_s_sync[0] <= i_s;
          r_r_sync[0] <= i_r;
          for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
            r_s_sync[k] <= r_s_sync[k-1];
            r_r_sync[k] <= r_r_sync[k-1];
          end
        end
      end

      assign w_s = r_s_sync[SYNC_STAGES-1];
      assign w_r = r_r_sync[SYNC_STAGES-1];
    end
  endgenerate

  assign w_forbidden = w_s & w_r;

  always_comb begin
    w_next = r_q;
    unique case ({w_s, w_r})
      2'b10:   w_next = 1'b1;
      2'b01:   w_next = 1'b0;
      2'b11: begin
        unique case (POLICY)
          POL_NOR, POL_RST_WINS: w_next = 1'b0;
          POL_SET_WINS:          w_next = 1'b1;
          POL_HOLD:              w_next = r_q;
          default:               w_next = r_q;
        endcase
      end
      default: w_next = r_q;
    endcase
  end

  // NOR policy clears the state too, so the cycle after the forbidden pair
  // always resumes from Q=0/QN=1 rather than from an ambiguous level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q       <= 1'b0;
      r_qn      <= 1'b1;
      r_invalid <= 1'b0;
    end else begin
      r_q       <= w_next;
      r_qn      <= (w_forbidden && (POLICY == POL_NOR)) ? 1'b0 : ~w_next;
      r_invalid <= w_forbidden;
    end
  end

  assign o_q         = r_q;
  assign o_qn        = r_qn;
  assign o_invalid   = r_invalid;
  assign o_forbidden = w_forbidden;

endmodule

// File: rtl/latch_sr.sv
// Bank of WIDTH independent clocked SR cells with a sticky flag recording
// any sampled S=R=1 since reset or the last err_clr.
module latch_sr
  import latch_sr_pkg::*;
#(
  parameter int unsigned WIDTH            = 1,
  parameter int unsigned SYNC_STAGES      = 0,
  parameter int unsigned FORBIDDEN_POLICY = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  latch_sr_if.slave  bus
);

  localparam int unsigned SYNC_EFF =
    (SYNC_STAGES > MAX_SYNC_STAGES) ? MAX_SYNC_STAGES : SYNC_STAGES;

  logic [WIDTH-1:0] w_forbidden;
  logic             r_err_sticky;

  generate
    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_cell
      latch_sr_cell #(
        .SYNC_STAGES      (SYNC_EFF),
        .FORBIDDEN_POLICY (FORBIDDEN_POLICY)
      ) u_cell (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_s         (bus.S[gi]),
        .i_r         (bus.R[gi]),
        .o_q         (bus.Q[gi]),
        .o_qn        (bus.QN[gi]),
        .o_invalid   (bus.invalid[gi]),
        .o_forbidden (w_forbidden[gi])
      );
    end
  endgenerate

  // Keyed on the forbidden pair being captured this edge, so the flag rises
  // together with invalid and a coincident clear cannot mask it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_sticky <= 1'b0;
    end else if (|w_forbidden) begin
      r_err_sticky <= 1'b1;
    end else if (bus.err_clr) begin
      r_err_sticky <= 1'b0;
    end
  end

  assign bus.err_sticky = r_err_sticky;

endmodule

// File: tb/tb_latch_sr.sv
// Directed bench for latch_sr across the four forbidden-state policies and a
// synchronized 4-bit configuration.
module tb_latch_sr;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  latch_sr_if #(.WIDTH(1)) b0 ();
  latch_sr_if #(.WIDTH(1)) b1 ();
  latch_sr_if #(.WIDTH(1)) b2 ();
  latch_sr_if #(.WIDTH(1)) b3 ();
  latch_sr_if #(.WIDTH(4)) b4 ();

  latch_sr #(.WIDTH(1), .SYNC_STAGES(0), .FORBIDDEN_POLICY(0))
    u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  latch_sr #(.WIDTH(1), .SYNC_STAGES(0), .FORBIDDEN_POLICY(1))
    u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  latch_sr #(.WIDTH(1), .SYNC_STAGES(0), .FORBIDDEN_POLICY(2))
    u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  latch_sr #(.WIDTH(1), .SYNC_STAGES(0), .FORBIDDEN_POLICY(3))
    u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  latch_sr #(.WIDTH(4), .SYNC_STAGES(2), .FORBIDDEN_POLICY(0))
    u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    b0.S = '0; b0.R = '0; b0.err_clr = 1'b0;
    b1.S = '0; b1.R = '0; b1.err_clr = 1'b0;
    b2.S = '0; b2.R = '0; b2.err_clr = 1'b0;
    b3.S = '0; b3.R = '0; b3.err_clr = 1'b0;
    b4.S = '0; b4.R = '0; b4.err_clr = 1'b0;

    #12;
    check("rst_q0",    b0.Q, 0);
    check("rst_qn0",   b0.QN, 1);
    check("rst_inv0",  b0.invalid, 0);
    check("rst_err0",  b0.err_sticky, 0);
    check("rst_q4",    b4.Q, 0);
    check("rst_qn4",   b4.QN, 64'hF);
    rst_n = 1'b1;

    // Scenario 1: set / reset / set
    b0.S = 1'b1; b0.R = 1'b0; tick();
    check("set_q",  b0.Q, 1);
    check("set_qn", b0.QN, 0);
    b0.S = 1'b0; b0.R = 1'b1; tick();
    check("rst_q",  b0.Q, 0);
    check("rst_qn", b0.QN, 1);
    b0.S = 1'b1; b0.R = 1'b0; tick();
    check("set2_q",  b0.Q, 1);
    check("set2_qn", b0.QN, 0);

    // Scenario 2: NOR forbidden then release
    b0.S = 1'b1; b0.R = 1'b1; tick();
    check("nor_q",   b0.Q, 0);
    check("nor_qn",  b0.QN, 0);
    check("nor_inv", b0.invalid, 1);
    check("nor_err", b0.err_sticky, 1);
    b0.S = 1'b0; b0.R = 1'b0; tick();
    check("rel_q",   b0.Q, 0);
    check("rel_qn",  b0.QN, 1);
    check("rel_inv", b0.invalid, 0);
    check("rel_err", b0.err_sticky, 1);

    // Scenario 3: hold for 20 cycles, then clear sticky
    b0.S = 1'b1; tick();
    b0.S = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_q",  b0.Q, 1);
      check("hold_qn", b0.QN, 0);
    end
    b0.err_clr = 1'b1; tick();
    check("clr_err", b0.err_sticky, 0);
    b0.err_clr = 1'b0; tick();
    check("clr_err_stays", b0.err_sticky, 0);

    // Scenario 6: forbidden on the same edge as err_clr
    b0.S = 1'b1; b0.R = 1'b1; b0.err_clr = 1'b1; tick();
    check("prio_err", b0.err_sticky, 1);
    check("prio_inv", b0.invalid, 1);
    b0.S = 1'b0; b0.R = 1'b0; tick();
    check("prio_err_after", b0.err_sticky, 0);
    b0.err_clr = 1'b0;

    // Scenario 4: policies 1/2/3 from Q=1
    b1.S = 1'b1; b2.S = 1'b1; b3.S = 1'b1; tick();
    check("p1_pre", b1.Q, 1);
    check("p2_pre", b2.Q, 1);
    check("p3_pre", b3.Q, 1);
    b1.R = 1'b1; b2.R = 1'b1; b3.R = 1'b1; tick();
    check("p1_q",   b1.Q, 0);
    check("p1_qn",  b1.QN, 1);
    check("p1_inv", b1.invalid, 1);
    check("p1_err", b1.err_sticky, 1);
    check("p2_q",   b2.Q, 1);
    check("p2_qn",  b2.QN, 0);
    check("p2_inv", b2.invalid, 1);
    check("p3_q",   b3.Q, 1);
    check("p3_qn",  b3.QN, 0);
    check("p3_inv", b3.invalid, 1);
    b1.S = 1'b0; b1.R = 1'b0; b2.S = 1'b0; b2.R = 1'b0;
    b3.S = 1'b0; b3.R = 1'b0; tick();
    check("p1_rel_q", b1.Q, 0);
    check("p2_rel_q", b2.Q, 1);
    check("p3_rel_q", b3.Q, 1);
    check("p3_rel_inv", b3.invalid, 0);

    // Scenario 5: two-stage synchronizer, 4 bits
    b4.S = 4'b0101; b4.R = 4'b0000; tick();
    check("sync_e1", b4.Q, 0);
    tick();
    check("sync_e2", b4.Q, 0);
    tick();
    check("sync_e3_q",  b4.Q, 64'h5);
    check("sync_e3_qn", b4.QN, 64'hA);
    b4.S = 4'b0011; b4.R = 4'b1100; tick(); tick();
    check("sync2_e2", b4.Q, 64'h5);
    tick();
    check("sync2_e3", b4.Q, 64'h3);
    b4.S = 4'b0010; b4.R = 4'b0010; tick(); tick();
    check("sync3_e2_inv", b4.invalid, 0);
    tick();
    check("sync3_q",   b4.Q, 64'h1);
    check("sync3_qn",  b4.QN, 64'hC);
    check("sync3_inv", b4.invalid, 64'h2);
    check("sync3_err", b4.err_sticky, 1);

    // Mid-stream asynchronous reset, with a set request in the synchronizer
    b4.S = 4'b1111; b4.R = 4'b0000; tick();
    #3 rst_n = 1'b0;
    #1;
    check("arst_q",   b4.Q, 0);
    check("arst_qn",  b4.QN, 64'hF);
    check("arst_inv", b4.invalid, 0);
    check("arst_err", b4.err_sticky, 0);
    check("arst_q0",  b0.Q, 0);
    b4.S = 4'b0000;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_q", b4.Q, 0);
    end

    // First edge after reset samples normally
    b0.S = 1'b1; tick();
    check("post_rst_q", b0.Q, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
